// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
//
// Purpose:
//   16550-style UART transmitter. Takes a byte from a holding register
//   (signalled by thre=0), frames it as start / 5-8 data bits (LSB first) /
//   optional parity / 1, 1.5 or 2 stop bits, and shifts it out on tx at one
//   bit per OVERSAMPLE baud_pulse ticks. Back-to-back bytes are sent with no
//   idle gap. set_break forces the line low without disturbing the FSM.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-low (wins over everything)
//   baud_pulse    in   one-clk-wide oversample tick
//   pen           in   parity enable
//   thre          in   holding register empty (0 = byte waiting on din)
//   stb           in   stop bits: 0 = 1, 1 = 2 (1.5 for 5-bit words)
//   sticky_parity in   stick parity enable
//   eps           in   even parity select
//   set_break     in   force line low
//   din[7:0]      in   data byte, LSB first
//   wls[1:0]      in   word length: 00=5, 01=6, 10=7, 11=8 bits
//   pop           out  one-clk pulse consuming the holding byte
//   sreg_empty    out  1 = shift register idle
//   tx            out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module uart_tx_top #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       pen,
    input  logic       thre,
    input  logic       stb,
    input  logic       sticky_parity,
    input  logic       eps,
    input  logic       set_break,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    output logic       pop,
    output logic       sreg_empty,
    output logic       tx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Last tick of a full bit period, and of a half bit period (the extra
    // half stop bit used for 5-bit words with stb=1).
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

    logic [2:0] r_state;
    logic [3:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_data;
    logic [1:0] r_wls;
    logic       r_pen;
    logic       r_eps;
    logic       r_sticky;
    logic       r_stb;
    logic       r_pop;
    logic       r_empty;
    logic       r_tx;

    logic       w_tick_last;
    logic       w_last_bit;
    logic       w_stop_end;
    logic       w_load;
    logic       w_parity;
    logic       w_line;
    logic [7:0] w_mask;

    assign w_tick_last = baud_pulse && (r_tick == TICK_LAST);

    // Index of the final data bit is 4 + wls, i.e. {1, wls}.
    assign w_last_bit  = (r_bit == {1'b1, r_wls});

    // Keep only the bits that are actually transmitted for the parity sum.
    assign w_mask      = 8'hFF >> (2'd3 - r_wls);

    // XOR of sent bits gives even parity; inverting it gives odd parity.
    assign w_parity    = r_sticky ? ~r_eps : ((^(r_data & w_mask)) ^ ~r_eps);

    // STOP uses r_bit as a second-period flag: period 0 is one full bit,
    // period 1 is the extra half or full bit when stb=1.
    assign w_stop_end  = (r_state == S_STOP) && baud_pulse &&
                         (((r_bit == 3'd0) && (r_tick == TICK_LAST) && !r_stb) ||
                          ((r_bit == 3'd1) &&
                           (r_tick == ((r_wls == 2'b00) ? TICK_HALF : TICK_LAST))));

    // A new byte is taken from IDLE, or straight from the end of STOP so
    // consecutive frames have no idle gap.
    assign w_load      = !thre && ((r_state == S_IDLE) || w_stop_end);

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_data[r_bit];
            S_PARITY: w_line = w_parity;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_tick   <= 4'd0;
            r_bit    <= 3'd0;
            r_data   <= 8'd0;
            r_wls    <= 2'd0;
            r_pen    <= 1'b0;
            r_eps    <= 1'b0;
            r_sticky <= 1'b0;
            r_stb    <= 1'b0;
            r_pop    <= 1'b0;
            r_empty  <= 1'b1;
            r_tx     <= 1'b1;
        end else begin
            r_pop <= 1'b0;
            r_tx  <= set_break ? 1'b0 : w_line;

            // The 4-bit tick counter wraps to 0 on its own at the end of
            // each full bit period; baud ticks are ignored in IDLE.
            if (baud_pulse && (r_state != S_IDLE)) begin
                r_tick <= r_tick + 4'd1;
            end

            case (r_state)
                S_START: begin
                    if (w_tick_last) begin
                        r_state <= S_DATA;
                        r_bit   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_tick_last) begin
                        if (w_last_bit) begin
                            r_bit   <= 3'd0;
                            r_state <= r_pen ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick_last) begin
                        r_state <= S_STOP;
                        r_bit   <= 3'd0;
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_state <= S_IDLE;
                        r_empty <= 1'b1;
                        r_tick  <= 4'd0;
                        r_bit   <= 3'd0;
                    end else if (w_tick_last) begin
                        r_bit <= 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= 4'd0;
                    r_bit   <= 3'd0;
                end
            endcase

            // Loading overrides whatever the state logic chose this edge.
            if (w_load) begin
                r_state  <= S_START;
                r_tick   <= 4'd0;
                r_bit    <= 3'd0;
                r_data   <= din;
                r_wls    <= wls;
                r_pen    <= pen;
                r_eps    <= eps;
                r_sticky <= sticky_parity;
                r_stb    <= stb;
                r_pop    <= 1'b1;
                r_empty  <= 1'b0;
            end
        end
    end

    assign pop        = r_pop;
    assign sreg_empty = r_empty;
    assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

    localparam int BAUD = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       pen;
    logic       thre;
    logic       stb;
    logic       sticky_parity;
    logic       eps;
    logic       set_break;
    logic [7:0] din;
    logic [1:0] wls;
    logic       pop;
    logic       sreg_empty;
    logic       tx;

    always #5 clk = ~clk;

    uart_tx_top #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .pen          (pen),
        .thre         (thre),
        .stb          (stb),
        .sticky_parity(sticky_parity),
        .eps          (eps),
        .set_break    (set_break),
        .din          (din),
        .wls          (wls),
        .pop          (pop),
        .sreg_empty   (sreg_empty),
        .tx           (tx)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         exp_q[$];          // expected line level per baud tick of current frame
    int         cur_total = 0;     // ticks in current frame (start..stop)
    int         tick_idx  = 0;     // baud ticks since current frame was loaded
    int         since     = 100;   // clocks since last baud tick
    int         pop_cnt   = 0;
    int         cyc       = 0;
    bit         mon_on    = 1'b0;
    logic       pop_prev  = 1'b0;
    logic [7:0] byte_q[$];         // further bytes to offer after each pop

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame: one entry per baud tick, from the framing rules.
    task automatic build_frame();
        int n;
        int ones;
        int par;
        int stop_len;
        exp_q.delete();
        n    = 5 + int'(wls);
        ones = 0;
        repeat (16) exp_q.push_back(0);
        for (int i = 0; i < n; i++) begin
            repeat (16) exp_q.push_back(int'(din[i]));
            ones += int'(din[i]);
        end
        if (pen) begin
            if (sticky_parity) par = eps ? 0 : 1;
            else               par = (ones % 2) ^ (eps ? 0 : 1);
            repeat (16) exp_q.push_back(par);
        end
        stop_len = !stb ? 16 : ((n == 5) ? 24 : 32);
        repeat (stop_len) exp_q.push_back(1);
        cur_total = exp_q.size();
        exp_q.push_back(1);
    endtask

    // Advance one clock, track baud ticks/pops, and check the line mid-tick.
    task automatic clk1();
        logic pulse_now;
        logic brk_now;
        @(posedge clk);
        pulse_now = baud_pulse;
        brk_now   = set_break;
        #1;
        cyc++;
        if (pulse_now) begin
            tick_idx++;
            since = 0;
        end else if (since < 100) begin
            since++;
        end
        if (pop) begin
            check("pop_width", pop_prev, 0);
            pop_cnt++;
            if (mon_on) begin
                build_frame();
                tick_idx = 0;
                if (!pulse_now) since = 100;
            end
            if (byte_q.size() > 0) din = byte_q.pop_front();
            else                   thre = 1'b1;
        end
        pop_prev = pop;
        if (mon_on && since == 3 && tick_idx < exp_q.size()) begin
            check("tx_bit", tx, brk_now ? 0 : exp_q[tick_idx]);
            check("sreg_empty", sreg_empty, (tick_idx >= cur_total) ? 1 : 0);
        end
        baud_pulse = ((cyc % BAUD) == 0);
    endtask

    task automatic wait_idle(input int target);
        bit done;
        int k;
        done = 1'b0;
        k    = 0;
        while (!done && k < 5000) begin
            clk1();
            k++;
            done = (pop_cnt >= target) && (tick_idx >= cur_total) && (since >= 4);
        end
        check("frame_done", done, 1);
        check("pop_count", pop_cnt, target);
    endtask

    task automatic wait_tick(input int target, input int idx);
        int k;
        k = 0;
        while (!(pop_cnt >= target && tick_idx >= idx) && k < 3000) begin
            clk1();
            k++;
        end
        check("reach_tick", (pop_cnt >= target && tick_idx >= idx) ? 1 : 0, 1);
    endtask

    task automatic rand_cfg();
        wls           = 2'($urandom_range(0, 3));
        pen           = 1'($urandom_range(0, 1));
        eps           = 1'($urandom_range(0, 1));
        stb           = 1'($urandom_range(0, 1));
        sticky_parity = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int t;
        rst           = 1'b0;
        thre          = 1'b1;
        baud_pulse    = 1'b0;
        pen           = 1'b0;
        stb           = 1'b0;
        sticky_parity = 1'b0;
        eps           = 1'b0;
        set_break     = 1'b0;
        din           = 8'h00;
        wls           = 2'b00;

        // Reset state
        repeat (3) clk1();
        check("rst_tx", tx, 1);
        check("rst_empty", sreg_empty, 1);
        check("rst_pop", pop, 0);
        rst    = 1'b1;
        mon_on = 1'b1;

        // Idle: baud ticks ignored, nothing sent
        repeat (60) clk1();
        check("idle_tx", tx, 1);
        check("idle_empty", sreg_empty, 1);
        check("idle_pops", pop_cnt, 0);

        // 8N-even, 2 stop bits, 0x13
        t = pop_cnt + 1;
        din = 8'h13; wls = 2'b11; pen = 1'b1; eps = 1'b1; stb = 1'b1; sticky_parity = 1'b0;
        thre = 1'b0;
        wait_idle(t);
        check("end_tx", tx, 1);
        check("end_empty", sreg_empty, 1);

        // 5-bit word, no parity, 1.5 stop bits
        t = pop_cnt + 1;
        din = 8'h1F; wls = 2'b00; pen = 1'b0; stb = 1'b1;
        thre = 1'b0;
        wait_idle(t);

        // Sticky parity, both polarities
        t = pop_cnt + 1;
        din = 8'($urandom); wls = 2'($urandom_range(0, 3)); pen = 1'b1; sticky_parity = 1'b1; eps = 1'b1; stb = 1'b0;
        thre = 1'b0;
        wait_idle(t);
        t = pop_cnt + 1;
        din = 8'($urandom); eps = 1'b0;
        thre = 1'b0;
        wait_idle(t);

        // Back-to-back frames with config changed mid-frame
        t = pop_cnt + 3;
        rand_cfg();
        din = 8'($urandom);
        byte_q.push_back(8'($urandom));
        byte_q.push_back(8'($urandom));
        thre = 1'b0;
        wait_tick(pop_cnt + 1, 40);
        rand_cfg();
        wait_idle(t);

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            din = 8'($urandom);
            t = pop_cnt + 1;
            if ($urandom_range(0, 1) == 1) begin
                byte_q.push_back(8'($urandom));
                t++;
            end
            thre = 1'b0;
            wait_idle(t);
        end

        // Break during DATA
        t = pop_cnt + 1;
        din = 8'hA5; wls = 2'b11; pen = 1'b0; stb = 1'b0; sticky_parity = 1'b0;
        thre = 1'b0;
        wait_tick(t, 20);
        set_break = 1'b1;
        repeat (40) clk1();
        check("break_tx", tx, 0);
        set_break = 1'b0;
        wait_idle(t);

        // Reset mid-DATA, with set_break also asserted
        t = pop_cnt + 1;
        din = 8'h00; wls = 2'b11; pen = 1'b1; eps = 1'b0; stb = 1'b1;
        thre = 1'b0;
        wait_tick(t, 40);
        mon_on    = 1'b0;
        rst       = 1'b0;
        set_break = 1'b1;
        clk1();
        check("rstmid_tx", tx, 1);
        check("rstmid_empty", sreg_empty, 1);
        check("rstmid_pop", pop, 0);
        rst       = 1'b1;
        set_break = 1'b0;
        exp_q.delete();
        cur_total = 0;
        repeat (40) clk1();
        check("post_rst_tx", tx, 1);
        check("post_rst_empty", sreg_empty, 1);
        mon_on = 1'b1;

        // Recovery frame after reset
        t = pop_cnt + 1;
        rand_cfg();
        din = 8'($urandom);
        thre = 1'b0;
        wait_idle(t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
UART_TX_TOP -- requirements
Module: uart_tx_top

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16: baud_pulse ticks per bit period; fixed 16 in all requirements below.
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port baud_pulse, input, 1, one-clk-wide 16x oversample tick.
REQ-005 The block SHALL have port pen, input, 1, parity enable.
REQ-006 The block SHALL have port thre, input, 1, holding register empty; 0 = byte waiting on din.
REQ-007 The block SHALL have port stb, input, 1, stop bits: 0 = 1 stop bit; 1 = 2 stop bits (1.5 for 5-bit words).
REQ-008 The block SHALL have port sticky_parity, input, 1, stick parity enable.
REQ-009 The block SHALL have port eps, input, 1, even parity select.
REQ-010 The block SHALL have port set_break, input, 1, force line low.
REQ-011 The block SHALL have port din, input, 8, data byte; LSB first.
REQ-012 The block SHALL have port wls, input, 2, word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-013 The block SHALL have port pop, output, 1, one-clk pulse consuming the holding byte.
REQ-014 The block SHALL have port sreg_empty, output, 1, 1 = shift register idle.
REQ-015 The block SHALL have port tx, output, 1, serial line; idle high.

Function
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: on a clk edge with thre=0, the FSM SHALL latch din, wls, pen, eps, sticky_parity and stb; pulse pop=1 for exactly that one clk; set sreg_empty=0; enter START.
REQ-018 The FSM SHALL hold tx=0 in START, data bit i (LSB first) in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-019 Each START, DATA-bit and PARITY period SHALL last exactly 16 baud_pulse ticks; a 4-bit tick counter SHALL advance only when baud_pulse=1, and the bit SHALL advance on the 16th tick.
REQ-020 DATA SHALL shift out 5/6/7/8 bits according to the latched wls, then go to PARITY if latched pen=1, else to STOP.
REQ-021 Parity bit with sticky_parity=0 SHALL be XOR of the transmitted data bits when eps=1 (even), and its inverse when eps=0 (odd); bits above the word length SHALL be excluded.
REQ-022 Parity bit with sticky_parity=1 SHALL be ~eps.
REQ-023 STOP SHALL last 16 ticks when stb=0, 24 ticks when stb=1 and word length is 5, and 32 ticks otherwise.
REQ-024 At STOP end with thre=0, the FSM SHALL load the next byte per REQ-017 and go directly to START with no idle gap.
REQ-025 At STOP end with thre=1, the FSM SHALL enter IDLE and set sreg_empty=1 on that same edge.
REQ-026 set_break=1 SHALL force tx=0 combinationally-registered on the next clk, in any state; the FSM SHALL keep running, and tx SHALL resume normal value on the clk after set_break falls.
REQ-027 Config input changes mid-frame SHALL NOT affect the frame in progress.
REQ-028 In IDLE, baud_pulse SHALL be ignored.

Reset
REQ-029 On a clk edge with rst=0, the block SHALL enter IDLE with tx=1, pop=0, sreg_empty=1, tick and bit counters cleared and latched data cleared, aborting any frame mid-operation.
REQ-030 rst SHALL take priority over every other input, including set_break.

Verification
REQ-031 Test: din=0x13, wls=11, pen=1, eps=1, stb=1, thre=0, baud_pulse every 6 clk -> pop pulses once, then tx = 0,1,1,0,0,1,0,0,0, parity 1, then 1 held for 32 ticks; each other bit held 16 ticks (96 clk).
REQ-032 Test: wls=00, pen=0, stb=1, din=0x1F -> 5 data ones, then 1 held for 24 ticks; bits 5-7 are not sent.
REQ-033 Test: sticky_parity=1, eps=1, pen=1 -> parity bit 0; with eps=0 -> parity bit 1, for any din.
REQ-034 Test: thre held 0 across two frames -> second start bit immediately follows the stop period; sreg_empty stays 0; pop pulses twice.
REQ-035 Test: set_break=1 mid-DATA -> tx=0 throughout; on release, tx tracks the FSM.
REQ-036 Test: rst=0 mid-DATA -> next edge gives tx=1, sreg_empty=1, pop=0.
